// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types, defaults and helpers for the fetch unit
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        STALL = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

    localparam int PC_W_DEF   = 8;
    localparam int JPTR_W_DEF = 6;
    localparam int PERF_W     = 16;

    // Saturating increment for the performance counters
    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (&v) ? v : v + PERF_W'(1);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - decoder/datapath/LUT-programming bundle of the fetch unit (FETCH_PERF_CNT_EN adds counters)
interface fetch_unit_if
    import fetch_pkg::*;
#(
    parameter int PC_W   = PC_W_DEF,
    parameter int JPTR_W = JPTR_W_DEF
);

    logic              Start;
    logic              Jen;
    logic [JPTR_W-1:0] Jptr;
    logic              BrTaken;
    logic              Stall;
    logic              DoneIn;
    logic              LutWe;
    logic [JPTR_W-1:0] LutAddr;
    logic [PC_W-1:0]   LutData;
    logic [PC_W-1:0]   ProgCtr;
    logic              Running;
    logic              Halted;
    logic              Overrun;
`ifdef FETCH_PERF_CNT_EN
    logic [PERF_W-1:0] CycleCnt;
    logic [PERF_W-1:0] InstrCnt;
`endif

    // Fetch-unit side
    modport slave (
        input  Start, Jen, Jptr, BrTaken, Stall, DoneIn, LutWe, LutAddr, LutData,
        output ProgCtr, Running, Halted, Overrun
`ifdef FETCH_PERF_CNT_EN
        , output CycleCnt, InstrCnt
`endif
    );

    // Decoder / control side
    modport master (
        output Start, Jen, Jptr, BrTaken, Stall, DoneIn, LutWe, LutAddr, LutData,
        input  ProgCtr, Running, Halted, Overrun
`ifdef FETCH_PERF_CNT_EN
        , input CycleCnt, InstrCnt
`endif
    );

endinterface

// File: rtl/fetch_unit_jump_lut.sv
// rtl/fetch_unit_jump_lut.sv - branch-pointer to PC-target table, sync write, async read, no reset
module jump_lut #(
    parameter int PC_W   = 8,
    parameter int JPTR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [JPTR_W-1:0] waddr,
    input  logic [PC_W-1:0]   wdata,
    input  logic [JPTR_W-1:0] raddr,
    output logic [PC_W-1:0]   rdata
);

    logic [PC_W-1:0] mem [2**JPTR_W];

    // Table write; a same-cycle read of the written entry still sees the old value
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC owner and start/run/stall/halt sequencer (FETCH_PERF_CNT_EN adds cycle/instr counters)
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          PC_W       = PC_W_DEF,
    parameter int          JPTR_W     = JPTR_W_DEF,
    parameter int unsigned START_ADDR = 0
) (
    input  logic         Clk,
    input  logic         Reset,
    fetch_unit_if.slave  bus
);

    localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            overrun_q, overrun_d;
    logic [PC_W-1:0] lut_rdata;
    logic [PC_W-1:0] pc_inc;
    logic            pc_wrap;
    logic            br_take;
    logic            start_accept;

    jump_lut #(
        .PC_W   (PC_W),
        .JPTR_W (JPTR_W)
    ) u_jump_lut (
        .clk   (Clk),
        .we    (bus.LutWe),
        .waddr (bus.LutAddr),
        .wdata (bus.LutData),
        .raddr (bus.Jptr),
        .rdata (lut_rdata)
    );

    assign pc_inc       = pc_q + PC_W'(1);
    assign pc_wrap      = &pc_q;
    assign br_take      = bus.Jen & bus.BrTaken;
    assign start_accept = bus.Start & ((state_q == IDLE) | (state_q == HALT));

    // State, PC and sticky overrun registers
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            overrun_q <= overrun_d;
        end
    end

    // Next-state and next-PC selection; halt beats stall beats branch beats increment
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        overrun_d = overrun_q;
        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    pc_d      = START_PC;
                    overrun_d = 1'b0;
                    state_d   = FETCH;
                end
            end
            FETCH: begin
                if (bus.DoneIn) begin
                    state_d = HALT;
                end else if (bus.Stall) begin
                    state_d = STALL;
                end else if (br_take) begin
                    pc_d = lut_rdata;
                end else begin
                    pc_d = pc_inc;
                    if (pc_wrap) overrun_d = 1'b1;
                end
            end
            STALL: begin
                // Stall is still high for the same instruction, so it is not looked at here
                state_d = FETCH;
                if (br_take) begin
                    pc_d = lut_rdata;
                end else begin
                    pc_d = pc_inc;
                    if (pc_wrap) overrun_d = 1'b1;
                end
            end
            HALT: begin
                if (bus.Start) begin
                    pc_d      = START_PC;
                    overrun_d = 1'b0;
                    state_d   = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.ProgCtr = pc_q;
    assign bus.Running = (state_q == FETCH) | (state_q == STALL);
    assign bus.Halted  = (state_q == HALT);
    assign bus.Overrun = overrun_q;

`ifdef FETCH_PERF_CNT_EN
    logic [PERF_W-1:0] cycle_cnt_q;
    logic [PERF_W-1:0] instr_cnt_q;

    // Every FETCH cycle either advances the PC or leaves FETCH, so it retires one instruction
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else if (start_accept) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            if (bus.Running)       cycle_cnt_q <= sat_inc(cycle_cnt_q);
            if (state_q == FETCH)  instr_cnt_q <= sat_inc(instr_cnt_q);
        end
    end

    assign bus.CycleCnt = cycle_cnt_q;
    assign bus.InstrCnt = instr_cnt_q;
`else
    logic unused_start_accept;
    assign unused_start_accept = start_accept;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;
    import fetch_pkg::*;

    logic Clk;
    logic Reset;
    int   checks;
    int   failures;

    fetch_unit_if #(.PC_W(8), .JPTR_W(6)) bus ();

    fetch_unit #(.PC_W(8), .JPTR_W(6), .START_ADDR(0)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.Start   = 1'b0;
        bus.Jen     = 1'b0;
        bus.Jptr    = '0;
        bus.BrTaken = 1'b0;
        bus.Stall   = 1'b0;
        bus.DoneIn  = 1'b0;
        bus.LutWe   = 1'b0;
        bus.LutAddr = '0;
        bus.LutData = '0;
    endtask

    // Reset then Start: leaves the DUT in FETCH with ProgCtr = 0
    task automatic reset_and_start();
        idle_inputs();
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        tick();
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
    endtask

    task automatic run_to(input logic [7:0] pc);
        for (int i = 0; i < 300 && bus.ProgCtr !== pc; i++) tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        Reset = 1'b0;
        #2;
        checks++;
        if ({bus.ProgCtr, bus.Running, bus.Halted, bus.Overrun} !== 11'h0) begin
            failures++;
            $display("FAIL reset_state got pc=%h run=%b halt=%b ovr=%b want 00/0/0/0",
                     bus.ProgCtr, bus.Running, bus.Halted, bus.Overrun);
        end
        tick();
        Reset = 1'b1;
        tick();
        checks++;
        if (bus.Running !== 1'b0 || bus.ProgCtr !== 8'h00) begin
            failures++;
            $display("FAIL idle_hold got pc=%h run=%b want 00/0", bus.ProgCtr, bus.Running);
        end
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        checks++;
        if (bus.ProgCtr !== 8'h00 || bus.Running !== 1'b1) begin
            failures++;
            $display("FAIL start got pc=%h run=%b want 00/1", bus.ProgCtr, bus.Running);
        end
    endtask

    task automatic test_sequential();
        reset_and_start();
        for (int i = 1; i <= 5; i++) begin
            tick();
            checks++;
            if (bus.ProgCtr !== 8'(i)) begin
                failures++;
                $display("FAIL seq_pc got %h want %h", bus.ProgCtr, 8'(i));
            end
        end
    endtask

    task automatic test_stall();
        logic [7:0] exp_pc [3];
        exp_pc[0] = 8'h03; exp_pc[1] = 8'h04; exp_pc[2] = 8'h05;
        reset_and_start();
        tick(); tick(); tick();
        bus.Stall = 1'b1;
        tick();
        checks++;
        if (bus.ProgCtr !== exp_pc[0] || bus.Running !== 1'b1) begin
            failures++;
            $display("FAIL stall_hold got pc=%h run=%b want %h/1", bus.ProgCtr, bus.Running, exp_pc[0]);
        end
        tick();
        bus.Stall = 1'b0;
        checks++;
        if (bus.ProgCtr !== exp_pc[1]) begin
            failures++;
            $display("FAIL stall_release got %h want %h", bus.ProgCtr, exp_pc[1]);
        end
        tick();
        checks++;
        if (bus.ProgCtr !== exp_pc[2]) begin
            failures++;
            $display("FAIL stall_resume got %h want %h", bus.ProgCtr, exp_pc[2]);
        end
    endtask

    task automatic test_branch();
        idle_inputs();
        Reset = 1'b1;
        bus.LutWe = 1'b1; bus.LutAddr = 6'd5; bus.LutData = 8'h40;
        tick();
        bus.LutAddr = 6'd6; bus.LutData = 8'h80;
        tick();
        bus.LutWe = 1'b0;
        reset_and_start();
        run_to(8'h07);
        bus.Jen = 1'b1; bus.Jptr = 6'd5; bus.BrTaken = 1'b1;
        tick();
        bus.Jen = 1'b0; bus.BrTaken = 1'b0;
        checks++;
        if (bus.ProgCtr !== 8'h40) begin
            failures++;
            $display("FAIL branch_taken got %h want 40", bus.ProgCtr);
        end
        // Branch presented during the STALL cycle must not be lost
        bus.Stall = 1'b1;
        tick();
        bus.Jen = 1'b1; bus.Jptr = 6'd6; bus.BrTaken = 1'b1;
        tick();
        bus.Stall = 1'b0; bus.Jen = 1'b0; bus.BrTaken = 1'b0;
        checks++;
        if (bus.ProgCtr !== 8'h80) begin
            failures++;
            $display("FAIL branch_in_stall got %h want 80", bus.ProgCtr);
        end
        // Same-cycle write and read of entry 5 returns the old target
        bus.LutWe = 1'b1; bus.LutAddr = 6'd5; bus.LutData = 8'h90;
        bus.Jen = 1'b1; bus.Jptr = 6'd5; bus.BrTaken = 1'b1;
        tick();
        bus.LutWe = 1'b0;
        checks++;
        if (bus.ProgCtr !== 8'h40) begin
            failures++;
            $display("FAIL lut_old_value got %h want 40", bus.ProgCtr);
        end
        tick();
        bus.Jen = 1'b0; bus.BrTaken = 1'b0;
        checks++;
        if (bus.ProgCtr !== 8'h90) begin
            failures++;
            $display("FAIL lut_new_value got %h want 90", bus.ProgCtr);
        end
        reset_and_start();
        run_to(8'h07);
        bus.Jen = 1'b1; bus.Jptr = 6'd5; bus.BrTaken = 1'b0;
        tick();
        bus.Jen = 1'b0;
        checks++;
        if (bus.ProgCtr !== 8'h08) begin
            failures++;
            $display("FAIL branch_not_taken got %h want 08", bus.ProgCtr);
        end
    endtask

    task automatic test_halt();
        int bad;
        reset_and_start();
        run_to(8'h12);
        bus.DoneIn = 1'b1;
        bus.Stall  = 1'b1;
        tick();
        bus.DoneIn = 1'b0;
        bus.Stall  = 1'b0;
        checks++;
        if (bus.Halted !== 1'b1 || bus.Running !== 1'b0 || bus.ProgCtr !== 8'h12) begin
            failures++;
            $display("FAIL halt_enter got halt=%b run=%b pc=%h want 1/0/12",
                     bus.Halted, bus.Running, bus.ProgCtr);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.ProgCtr !== 8'h12 || bus.Halted !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL halt_frozen got %0d bad cycles want 0", bad);
        end
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        checks++;
        if (bus.ProgCtr !== 8'h00 || bus.Running !== 1'b1 || bus.Halted !== 1'b0) begin
            failures++;
            $display("FAIL halt_restart got pc=%h run=%b halt=%b want 00/1/0",
                     bus.ProgCtr, bus.Running, bus.Halted);
        end
        tick(); tick();
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        checks++;
        if (bus.ProgCtr !== 8'h03) begin
            failures++;
            $display("FAIL start_in_fetch got %h want 03", bus.ProgCtr);
        end
    endtask

    task automatic test_wrap_and_reset_mid();
        reset_and_start();
        run_to(8'hFF);
        checks++;
        if (bus.ProgCtr !== 8'hFF || bus.Overrun !== 1'b0) begin
            failures++;
            $display("FAIL pre_wrap got pc=%h ovr=%b want FF/0", bus.ProgCtr, bus.Overrun);
        end
        tick();
        checks++;
        if (bus.ProgCtr !== 8'h00 || bus.Overrun !== 1'b1 || bus.Running !== 1'b1) begin
            failures++;
            $display("FAIL wrap got pc=%h ovr=%b run=%b want 00/1/1", bus.ProgCtr, bus.Overrun, bus.Running);
        end
        run_to(8'h23);
        checks++;
        if (bus.Overrun !== 1'b1 || bus.ProgCtr !== 8'h23) begin
            failures++;
            $display("FAIL overrun_sticky got pc=%h ovr=%b want 23/1", bus.ProgCtr, bus.Overrun);
        end
        #2;
        Reset = 1'b0;
        #1;
        checks++;
        if ({bus.ProgCtr, bus.Running, bus.Halted, bus.Overrun} !== 11'h0) begin
            failures++;
            $display("FAIL reset_mid got pc=%h run=%b halt=%b ovr=%b want 00/0/0/0",
                     bus.ProgCtr, bus.Running, bus.Halted, bus.Overrun);
        end
        tick();
        Reset = 1'b1;
        tick();
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        checks++;
        if (bus.ProgCtr !== 8'h00 || bus.Running !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_restart got pc=%h run=%b want 00/1", bus.ProgCtr, bus.Running);
        end
        // Overrun cleared by Start out of HALT
        run_to(8'hFF);
        tick();
        bus.DoneIn = 1'b1;
        tick();
        bus.DoneIn = 1'b0;
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        checks++;
        if (bus.Overrun !== 1'b0 || bus.ProgCtr !== 8'h00) begin
            failures++;
            $display("FAIL overrun_clear got pc=%h ovr=%b want 00/0", bus.ProgCtr, bus.Overrun);
        end
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf();
        reset_and_start();
        checks++;
        if (bus.CycleCnt !== 16'd0 || bus.InstrCnt !== 16'd0) begin
            failures++;
            $display("FAIL perf_clear got cyc=%0d ins=%0d want 0/0", bus.CycleCnt, bus.InstrCnt);
        end
        tick();
        bus.Stall = 1'b1;
        tick();
        tick();
        bus.Stall = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.CycleCnt !== 16'd5 || bus.InstrCnt !== 16'd4) begin
            failures++;
            $display("FAIL perf_counts got cyc=%0d ins=%0d want 5/4", bus.CycleCnt, bus.InstrCnt);
        end
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        Reset    = 1'b0;
        idle_inputs();
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_halt();
        test_wrap_and_reset_mid();
`ifdef FETCH_PERF_CNT_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
